// File: rtl/carry_period_meas.sv
// carry_period_meas: measures carry-chain period from thermometer snapshots and sums 2^AVG_LOG2 good widths
// ports: c/r clock and sync reset; snap/snap_valid/snap_ready snapshot input handshake;
//        d/d_valid/d_ready accumulated width output handshake; miss_cnt saturating count of rejected snapshots
module carry_period_meas #(
  parameter int TAPS = 100,
  parameter int GUARD = 7,
  parameter int AVG_LOG2 = 4,
  parameter int EDGE_MODE = 0,
  parameter int W = $clog2(TAPS) + AVG_LOG2
) (
  input  logic            c,
  input  logic            r,
  input  logic [TAPS-1:0] snap,
  input  logic            snap_valid,
  output logic            snap_ready,
  output logic [W-1:0]    d,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [7:0]      miss_cnt
);
  localparam int KW = $clog2(TAPS);
  localparam int GW = $clog2(GUARD + 1);
  localparam int NW = AVG_LOG2 + 1;
  localparam int TERM = EDGE_MODE != 0 ? 2 : 3;
  localparam logic [NW-1:0] NLAST = NW'((1 << AVG_LOG2) - 1);
  typedef enum logic [1:0] {IDLE, SCAN, ACC, OUT} state_t;
  state_t st, nx;
  logic [TAPS-1:0] sq;
  logic [KW-1:0] k, k1, wid;
  logic [GW-1:0] g;
  logic [1:0] ec;
  logic [W-1:0] sum;
  logic [NW-1:0] n;
  logic edge_hit, term, last, full;
  // a transition only counts once GUARD quiet taps have passed, which swallows bubbles
  assign edge_hit = (sq[k] ^ sq[k + KW'(1)]) && g == GW'(GUARD);
  assign term = edge_hit && ec == 2'(TERM - 1);
  assign last = k == KW'(TAPS - 2);
  assign full = n == NLAST;
  always_ff @(posedge c)
    st <= r ? IDLE : nx;
  always_comb
    nx = st == IDLE ? (snap_valid ? SCAN : IDLE)
       : st == SCAN ? (term ? ACC : last ? IDLE : SCAN)
       : st == ACC  ? (full ? OUT : IDLE)
       : (d_ready ? IDLE : OUT);
  always_comb begin
    snap_ready = st == IDLE;
    d_valid = st == OUT;
    d = st == OUT ? sum : '0;
  end
  always_ff @(posedge c)
    if (r) begin
      sum <= '0;
      n <= '0;
      miss_cnt <= '0;
    end else begin
      if (st == IDLE && snap_valid) begin
        sq <= snap;
        k <= '0;
        g <= GW'(GUARD);
        ec <= '0;
      end
      if (st == SCAN) begin
        k <= k + KW'(1);
        g <= edge_hit ? '0 : g == GW'(GUARD) ? g : g + GW'(1);
        if (edge_hit) ec <= ec + 2'd1;
        if (edge_hit && ec == 2'd0) k1 <= k;
        if (term) wid <= k - k1;
        if (last && !term && miss_cnt != 8'hff) miss_cnt <= miss_cnt + 8'd1;
      end
      if (st == ACC) begin
        sum <= sum + W'(wid);
        n <= n + NW'(1);
      end
      if (st == OUT && d_ready) begin
        sum <= '0;
        n <= '0;
      end
    end
endmodule

// File: tb/tb_carry_period_meas.sv
// tb_carry_period_meas: directed checks of carry_period_meas in full- and half-period modes
module tb_carry_period_meas;
  logic c = 1'b0, r = 1'b0, sv0 = 1'b0, sv1 = 1'b0, dr = 1'b0;
  logic [99:0] snap = '0;
  logic sr0, sr1, dv0, dv1;
  logic [8:0] d0, d1;
  logic [7:0] m0, m1;
  logic [99:0] p, b, mp;
  int total = 0, bad = 0;

  carry_period_meas #(.TAPS(100), .GUARD(7), .AVG_LOG2(2), .EDGE_MODE(0)) dut0 (
    .c(c), .r(r), .snap(snap), .snap_valid(sv0), .snap_ready(sr0),
    .d(d0), .d_valid(dv0), .d_ready(dr), .miss_cnt(m0));
  carry_period_meas #(.TAPS(100), .GUARD(7), .AVG_LOG2(2), .EDGE_MODE(1)) dut1 (
    .c(c), .r(r), .snap(snap), .snap_valid(sv1), .snap_ready(sr1),
    .d(d1), .d_valid(dv1), .d_ready(dr), .miss_cnt(m1));

  always #5 c = ~c;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rdy(input int m);
    return m == 0 ? int'(sr0) : int'(sr1);
  endfunction

  function automatic int dvl(input int m);
    return m == 0 ? int'(dv0) : int'(dv1);
  endfunction

  function automatic int dat(input int m);
    return m == 0 ? int'(d0) : int'(d1);
  endfunction

  task automatic send(input int m, input logic [99:0] v);
    int t = 0;
    snap = v;
    if (m == 0) sv0 = 1'b1; else sv1 = 1'b1;
    while (rdy(m) == 0 && t < 400) begin
      @(negedge c);
      t++;
    end
    if (t >= 400) chk("send_timeout", t, 0);
    @(negedge c);
    sv0 = 1'b0;
    sv1 = 1'b0;
  endtask

  task automatic wait_idle(input int m);
    int t = 0;
    while (rdy(m) == 0 && t < 300) begin
      @(negedge c);
      t++;
    end
    if (t >= 300) chk("idle_timeout", t, 0);
  endtask

  task automatic send_n_idle(input int m, input logic [99:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) send(m, v);
    wait_idle(m);
    chk("no_early_d_valid", dvl(m), 0);
  endtask

  task automatic meas(input int m, input logic [99:0] v, input int cnt, input int exp_d,
                      input int exp_lat, input int hold);
    int t = 0;
    for (int i = 0; i < cnt; i++) send(m, v);
    while (dvl(m) == 0 && t < 300) begin
      @(negedge c);
      t++;
    end
    chk("latency", t, exp_lat);
    chk("d", dat(m), exp_d);
    chk("d_valid", dvl(m), 1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_d", dat(m), exp_d);
      chk("hold_d_valid", dvl(m), 1);
      chk("hold_snap_ready", rdy(m), 0);
      @(negedge c);
    end
    dr = 1'b1;
    @(negedge c);
    dr = 1'b0;
    chk("post_snap_ready", rdy(m), 1);
    chk("post_d_valid", dvl(m), 0);
    chk("post_d", dat(m), 0);
  endtask

  initial begin
    for (int i = 0; i < 100; i++) begin
      p[i] = (i >= 11 && i <= 30) || i >= 51;
      mp[i] = i >= 11 && i <= 30;
    end
    b = p;
    b[12] = ~b[12];
    snap = p;
    r = 1'b1;
    sv0 = 1'b1;
    @(negedge c);
    @(negedge c);
    chk("rst_snap_ready", int'(sr0), 1);
    chk("rst_d_valid", int'(dv0), 0);
    chk("rst_d", int'(d0), 0);
    chk("rst_miss", int'(m0), 0);
    r = 1'b0;
    sv0 = 1'b0;
    @(negedge c);
    chk("ready_after_rst", int'(sr0), 1);
    meas(0, p, 4, 160, 52, 10);
    chk("miss_after_good", int'(m0), 0);
    meas(0, b, 4, 160, 52, 0);
    send(0, mp);
    wait_idle(0);
    chk("miss_one", int'(m0), 1);
    send_n_idle(0, p, 3);
    meas(0, p, 1, 160, 52, 0);
    chk("miss_still_one", int'(m0), 1);
    send_n_idle(0, p, 2);
    send(0, p);
    repeat (5) @(negedge c);
    r = 1'b1;
    @(negedge c);
    r = 1'b0;
    chk("midscan_rst_ready", int'(sr0), 1);
    chk("midscan_rst_miss", int'(m0), 0);
    chk("midscan_rst_d_valid", int'(dv0), 0);
    send_n_idle(0, p, 3);
    meas(0, p, 1, 160, 52, 0);
    meas(1, p, 4, 80, 32, 0);
    chk("half_miss", int'(m1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/carry_period_meas.md
CARRY_PERIOD_MEAS -- requirements
Module: carry_period_meas

Interface
REQ-001 SHALL have parameter TAPS, default 100: width of the thermometer snapshot (carry-chain taps).
REQ-002 SHALL have parameter GUARD, default 7: minimum tap spacing between counted edges (bubble suppression).
REQ-003 SHALL have parameter AVG_LOG2, default 4: accumulate 2^AVG_LOG2 good measurements per output.
REQ-004 SHALL have parameter EDGE_MODE, default 0: 0 = width edge1->edge3 (full period), 1 = edge1->edge2 (half period).
REQ-005 SHALL have derived width W = clog2(TAPS) + AVG_LOG2.
REQ-006 SHALL have port c  input  1  clock; all logic on its rising edge.
REQ-007 SHALL have port r  input  1  reset; synchronous, active-high.
REQ-008 SHALL have port snap  input  TAPS  captured delay-line state; bit 0 = earliest tap.
REQ-009 SHALL have port snap_valid  input  1  snap is valid.
REQ-010 SHALL have port snap_ready  output  1  block accepts snap this cycle.
REQ-011 SHALL have port d  output  W  accumulated width sum; unsigned fixed point, AVG_LOG2 fraction bits (mean taps).
REQ-012 SHALL have port d_valid  output  1  d is valid.
REQ-013 SHALL have port d_ready  input  1  consumer accepts d.
REQ-014 SHALL have port miss_cnt  output  8  count of rejected snapshots, saturating at 255.

Function
REQ-015 SHALL implement states IDLE, SCAN, ACC and OUT.
REQ-016 SHALL drive snap_ready high only in IDLE; a snapshot transfers when snap_valid && snap_ready, is registered internally, and the next state is SCAN with tap index k=0.
REQ-017 SHALL, in SCAN, examine exactly one tap pair (k, k+1) per cycle; a transition is snap[k] ^ snap[k+1].
REQ-018 SHALL keep a guard counter g, saturating at GUARD and initialised to GUARD on entry to SCAN; a transition counts as an edge only when g == GUARD, which then clears g to 0; otherwise g increments each SCAN cycle.
REQ-019 SHALL record k of the first counted edge as k1.
REQ-020 SHALL, on the terminating edge (the 3rd counted edge if EDGE_MODE=0, the 2nd if EDGE_MODE=1) at index k, set width = k - k1 and go to ACC the next cycle (early exit).
REQ-021 SHALL, when k = TAPS-2 is examined without a terminating edge, increment miss_cnt (saturating), discard the snapshot and return to IDLE; the accumulator is untouched.
REQ-022 SHALL limit a SCAN to at most TAPS-1 cycles.
REQ-023 SHALL, in ACC (one cycle), do sum += width and n += 1; if n reaches 2^AVG_LOG2 go to OUT, else IDLE.
REQ-024 SHALL, in OUT, hold d_valid = 1 with d = sum stable until d_ready is high; on that cycle clear sum and n and go to IDLE.
REQ-025 SHALL hold sum and d wide enough that 2^AVG_LOG2 * (TAPS-1) cannot overflow.
REQ-026 SHALL keep d_valid low and d at 0 in all states other than OUT.
REQ-027 SHALL ignore snap_valid outside IDLE; no snapshot is queued.
REQ-028 SHALL give accept-to-ACC latency of (k_terminating + 1) SCAN cycles; an IDLE->IDLE loop with a continuously valid source takes k_term+3 cycles.

Reset
REQ-029 SHALL, when r is high at a rising edge, set state = IDLE, sum = 0, n = 0, miss_cnt = 0, d = 0 and d_valid = 0, regardless of current state.
REQ-030 SHALL give r priority over any simultaneous handshake; a snapshot offered in a reset cycle is not accepted, and a pending d is dropped.
REQ-031 SHALL drive snap_ready = 1 on the first cycle after r deasserts.

Verification (TAPS=100, GUARD=7, AVG_LOG2=2, EDGE_MODE=0 unless noted)
REQ-032 SHALL cover: 4 snapshots with bits 0-10=0, 11-30=1, 31-50=0, 51-99=1 -> one d_valid, d=160 (40.00 taps), miss_cnt=0.
REQ-033 SHALL cover: same pattern with bit 12 inverted (bubble at pairs 11, 12) -> bubble ignored, d=160.
REQ-034 SHALL cover: snapshot with only transitions at pairs 10 and 30 -> miss_cnt=1, no accumulation; then 4 good snapshots -> d=160.
REQ-035 SHALL cover: d_ready low for 10 cycles in OUT -> d and d_valid held, snap_ready=0 throughout; d_ready high -> IDLE the next cycle.
REQ-036 SHALL cover: r pulsed mid-SCAN after 2 good measurements -> all state cleared; 4 further good snapshots are needed for the next d=160.
REQ-037 SHALL cover: EDGE_MODE=1 with the REQ-032 pattern -> d=80, SCAN exits at k=30.
